// File: rtl/dma_axis_to_axi4_wr_engine_pkg.sv
// Shared types for the AXI-Stream -> AXI4 DMA write direction.
// Covers the write-engine FSM states, the AXI enums and the DMA window mode.
package dma_axis_to_axi4_wr_engine_pkg;

  typedef enum logic [2:0] {
    WR_IDLE = 3'd0,
    WR_CALC = 3'd1,
    WR_AW   = 3'd2,
    WR_W    = 3'd3,
    WR_B    = 3'd4,
    WR_DONE = 3'd5
  } wr_state_t;

  typedef enum logic [2:0] {
    AXSIZE_1B   = 3'd0,
    AXSIZE_2B   = 3'd1,
    AXSIZE_4B   = 3'd2,
    AXSIZE_8B   = 3'd3,
    AXSIZE_16B  = 3'd4,
    AXSIZE_32B  = 3'd5,
    AXSIZE_64B  = 3'd6,
    AXSIZE_128B = 3'd7
  } axsize_t;

  typedef enum logic [1:0] {
    AXBURST_FIXED = 2'd0,
    AXBURST_INCR  = 2'd1,
    AXBURST_WRAP  = 2'd2
  } axburst_t;

  typedef enum logic [1:0] {
    XRESP_OKAY   = 2'd0,
    XRESP_EXOKAY = 2'd1,
    XRESP_SLVERR = 2'd2,
    XRESP_DECERR = 2'd3
  } xresp_t;

  typedef enum logic {
    DMA_DIRECT_MODE   = 1'b0,
    DMA_CIRCULAR_MODE = 1'b1
  } dma_axis_axi4_moder_t;

  // AxSIZE encoding for a beat of bpb bytes (bpb is a power of two).
  function automatic axsize_t axsize_of(input int bpb);
    return axsize_t'(3'($clog2(bpb)));
  endfunction

endpackage

// File: rtl/dma_axi4_burst_calc.sv
// Burst length for the next AXI4 INCR write: the smallest of MAX_BURST, the remaining
// beats, the beats left before the 4KB boundary and, in circular mode, the beats left before max_addr.
module dma_axi4_burst_calc
  import dma_axis_to_axi4_wr_engine_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 32,
  parameter int BPB_LOG   = 3,
  parameter int MAX_BURST = 16
) (
  input  logic [ADDR_W-1:0]    cur_addr_i,
  input  logic [LEN_W-1:0]     rem_i,
  input  logic [ADDR_W-1:0]    max_addr_i,
  input  dma_axis_axi4_moder_t mode_i,
  output logic [8:0]           blen_o
);

  localparam logic [8:0] MB = 9'(MAX_BURST);

  logic [12:0]       bytes_4k;
  logic [12:0]       beats_4k;
  logic [ADDR_W-1:0] beats_circ;
  logic [8:0]        c_rem;
  logic [8:0]        c_4k;
  logic [8:0]        c_circ;
  logic [8:0]        blen;

  // Each candidate is clamped to MAX_BURST first so the final minimum fits in 9 bits.
  always_comb begin
    bytes_4k   = 13'h1000 - {1'b0, cur_addr_i[11:0]};
    beats_4k   = bytes_4k >> BPB_LOG;
    beats_circ = (max_addr_i - cur_addr_i) >> BPB_LOG;
    c_rem      = (rem_i >= LEN_W'(MAX_BURST)) ? MB : rem_i[8:0];
    c_4k       = (beats_4k >= 13'(MAX_BURST)) ? MB : beats_4k[8:0];
    c_circ     = (beats_circ >= ADDR_W'(MAX_BURST)) ? MB : beats_circ[8:0];
    blen       = MB;
    if (c_rem < blen) blen = c_rem;
    if (c_4k < blen) blen = c_4k;
    if ((mode_i == DMA_CIRCULAR_MODE) && (c_circ < blen)) blen = c_circ;
    blen_o = blen;
  end

endmodule

// File: rtl/dma_axis_to_axi4_wr_engine.sv
// Stream-to-AXI4 write engine: drains stream beats into INCR bursts over [min_addr, max_addr),
// one burst outstanding. Handshake: a transfer happens on a clock edge where valid && ready.
module dma_axis_to_axi4_wr_engine
  import dma_axis_to_axi4_wr_engine_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 32,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 flush,
  input  dma_axis_axi4_moder_t cfg_mode,
  input  logic [ADDR_W-1:0]    cfg_min_addr,
  input  logic [ADDR_W-1:0]    cfg_max_addr,
  input  logic [LEN_W-1:0]     cfg_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W-1:0]    cur_addr,
  output logic [LEN_W-1:0]     beats_done,
  output logic [2:0]           dbg_state,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [ID_W-1:0]      m_axi_awid,
  output logic [ADDR_W-1:0]    m_axi_awaddr,
  output logic [7:0]           m_axi_awlen,
  output logic [2:0]           m_axi_awsize,
  output logic [1:0]           m_axi_awburst,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [DATA_W-1:0]    m_axi_wdata,
  output logic [DATA_W/8-1:0]  m_axi_wstrb,
  output logic                 m_axi_wlast,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [ID_W-1:0]      m_axi_bid,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready
);

  localparam int BPB     = DATA_W / 8;
  localparam int BPB_LOG = $clog2(BPB);

  wr_state_t            state_q, state_d;
  dma_axis_axi4_moder_t mode_q, mode_d;
  logic [ADDR_W-1:0]    min_q, min_d, max_q, max_d, cur_addr_q, cur_addr_d, next_addr;
  logic [LEN_W-1:0]     rem_q, rem_d, beats_done_q, beats_done_d;
  logic [8:0]           blen_q, blen_d, beat_cnt_q, beat_cnt_d, calc_blen;
  logic                 err_q, err_d, flush_q, flush_d;
  logic                 window_bad, last_beat, w_beat;
  logic                 unused_bid;

  dma_axi4_burst_calc #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .BPB_LOG  (BPB_LOG),
    .MAX_BURST(MAX_BURST)
  ) u_burst_calc (
    .cur_addr_i(cur_addr_q),
    .rem_i     (rem_q),
    .max_addr_i(max_q),
    .mode_i    (mode_q),
    .blen_o    (calc_blen)
  );

  assign window_bad = (mode_q == DMA_CIRCULAR_MODE) && (max_q <= min_q);
  assign last_beat  = (beat_cnt_q == (blen_q - 9'd1));
  assign w_beat     = (state_q == WR_W) && s_axis_tvalid && m_axi_wready;
  assign next_addr  = cur_addr_q + (ADDR_W'(blen_q) << BPB_LOG);
  assign unused_bid = ^m_axi_bid;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    min_d        = min_q;
    max_d        = max_q;
    cur_addr_d   = cur_addr_q;
    rem_d        = rem_q;
    beats_done_d = beats_done_q;
    blen_d       = blen_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    flush_d      = flush_q;
    case (state_q)
      WR_IDLE: begin
        if (start) begin
          mode_d       = cfg_mode;
          min_d        = cfg_min_addr;
          max_d        = cfg_max_addr;
          cur_addr_d   = cfg_min_addr;
          rem_d        = cfg_len >> BPB_LOG;
          beats_done_d = '0;
          flush_d      = 1'b0;
          err_d        = (cfg_mode == DMA_CIRCULAR_MODE) && (cfg_max_addr <= cfg_min_addr);
          state_d      = WR_CALC;
        end
      end
      // Empty or invalid jobs also pass through CALC, so done lands two cycles after start.
      WR_CALC: begin
        if ((rem_q == '0) || window_bad) begin
          state_d = WR_DONE;
        end else begin
          blen_d  = calc_blen;
          state_d = WR_AW;
        end
      end
      WR_AW: begin
        if (m_axi_awready) begin
          beat_cnt_d = '0;
          state_d    = WR_W;
        end
      end
      WR_W: begin
        if (w_beat) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (last_beat) state_d = WR_B;
        end
      end
      WR_B: begin
        if (m_axi_bvalid) begin
          beats_done_d = beats_done_q + LEN_W'(blen_q);
          rem_d        = rem_q - LEN_W'(blen_q);
          cur_addr_d   = ((mode_q == DMA_CIRCULAR_MODE) && (next_addr == max_q)) ? min_q : next_addr;
          if (m_axi_bresp != XRESP_OKAY) begin
            err_d   = 1'b1;
            state_d = WR_DONE;
          end else if ((rem_d == '0) || flush_q || flush) begin
            state_d = WR_DONE;
          end else begin
            state_d = WR_CALC;
          end
        end
      end
      WR_DONE: state_d = WR_IDLE;
      default: state_d = WR_IDLE;
    endcase
    // A flush only ever ends the job after the burst in flight has been acknowledged.
    if ((state_q != WR_IDLE) && flush) flush_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= WR_IDLE;
      mode_q       <= DMA_DIRECT_MODE;
      min_q        <= '0;
      max_q        <= '0;
      cur_addr_q   <= '0;
      rem_q        <= '0;
      beats_done_q <= '0;
      blen_q       <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      min_q        <= min_d;
      max_q        <= max_d;
      cur_addr_q   <= cur_addr_d;
      rem_q        <= rem_d;
      beats_done_q <= beats_done_d;
      blen_q       <= blen_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
      flush_q      <= flush_d;
    end
  end

  assign busy       = (state_q != WR_IDLE);
  assign done       = (state_q == WR_DONE);
  assign err        = err_q;
  assign cur_addr   = cur_addr_q;
  assign beats_done = beats_done_q;
  assign dbg_state  = state_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = cur_addr_q;
  assign m_axi_awlen   = 8'(blen_q - 9'd1);
  assign m_axi_awsize  = axsize_of(BPB);
  assign m_axi_awburst = AXBURST_INCR;
  assign m_axi_awvalid = (state_q == WR_AW);

  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_q == WR_W) && last_beat;
  assign m_axi_wvalid  = (state_q == WR_W) && s_axis_tvalid;
  assign s_axis_tready = (state_q == WR_W) && m_axi_wready;
  assign m_axi_bready  = (state_q == WR_B);

endmodule

// File: tb/tb_dma_axis_to_axi4_wr_engine.sv
// Directed bench for the stream-to-AXI4 write engine with a reactive AXI slave and stream source.
module tb_dma_axis_to_axi4_wr_engine;
  import dma_axis_to_axi4_wr_engine_pkg::*;

  localparam int ADDR_W = 32, DATA_W = 64, LEN_W = 32, MAX_BURST = 16, ID_W = 4;

  logic clk, rstn, start, flush;
  dma_axis_axi4_moder_t cfg_mode;
  logic [ADDR_W-1:0] cfg_min_addr, cfg_max_addr, cur_addr;
  logic [LEN_W-1:0]  cfg_len, beats_done;
  logic busy, done, err;
  logic [2:0] dbg_state;
  logic [DATA_W-1:0] s_axis_tdata, m_axi_wdata;
  logic s_axis_tvalid, s_axis_tready;
  logic [ID_W-1:0] m_axi_awid, m_axi_bid;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize;
  logic [1:0] m_axi_awburst, m_axi_bresp;
  logic m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic m_axi_bvalid, m_axi_bready;

  dma_axis_to_axi4_wr_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .flush(flush), .cfg_mode(cfg_mode),
    .cfg_min_addr(cfg_min_addr), .cfg_max_addr(cfg_max_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err), .cur_addr(cur_addr), .beats_done(beats_done),
    .dbg_state(dbg_state),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and bus logs ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_W-1:0] aw_addr_log[$];
  logic [7:0]        aw_len_log[$];
  int w_total, w_bad, aw_bad, b_total, b_pend, w_beat, w_burst_idx;
  logic [DATA_W-1:0] exp_data;
  logic aw_stall, w_stall, t_gaps;
  int err_burst;

  // ---------------- AXI slave + stream source ----------------
  // Inputs change on the falling edge; the handshake that the next rising edge will see is recorded 1ns later.
  initial begin
    bit last_exp;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00; m_axi_bid = '0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    w_total = 0; w_bad = 0; aw_bad = 0; b_total = 0; b_pend = 0; w_beat = 0; w_burst_idx = 0;
    exp_data = 64'hA5A5_0000_0000_0000;
    forever begin
      @(negedge clk);
      m_axi_awready = aw_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = w_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tvalid = t_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tdata  = exp_data;
      m_axi_bvalid  = (b_pend > 0);
      m_axi_bresp   = (b_total == err_burst) ? 2'b10 : 2'b00;
      #1;
      if ((dbg_state != 3'(WR_W) && s_axis_tready) ||
          (dbg_state == 3'(WR_W) && s_axis_tready !== m_axi_wready)) w_bad++;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_addr_log.push_back(m_axi_awaddr);
        aw_len_log.push_back(m_axi_awlen);
        if (m_axi_awsize !== 3'd3 || m_axi_awburst !== 2'b01 || m_axi_awid !== '0) aw_bad++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_burst_idx >= aw_len_log.size()) begin
          w_bad++;
        end else begin
          last_exp = (w_beat == int'(aw_len_log[w_burst_idx]));
          if (m_axi_wdata !== exp_data || m_axi_wstrb !== 8'hFF || m_axi_wlast !== last_exp) w_bad++;
          w_beat++;
          if (last_exp) begin
            w_beat = 0;
            w_burst_idx++;
            b_pend++;
          end
        end
        w_total++;
        exp_data = exp_data + 64'd1;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pend--;
        b_total++;
      end
    end
  end

  // ---------------- driver tasks / checks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] aw_addr_at(input int i);
    return (i < aw_addr_log.size()) ? 64'(aw_addr_log[i]) : 64'hDEAD_DEAD;
  endfunction

  function automatic logic [63:0] aw_len_at(input int i);
    return (i < aw_len_log.size()) ? 64'(aw_len_log[i]) : 64'hDEAD_DEAD;
  endfunction

  task automatic do_start(input dma_axis_axi4_moder_t mode, input logic [31:0] mn,
                          input logic [31:0] mx, input logic [31:0] len);
    @(negedge clk);
    cfg_mode = mode; cfg_min_addr = mn; cfg_max_addr = mx; cfg_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check({tag, "_done_drop"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int aw_base, wt_base, lat;
    rstn = 1'b0; start = 1'b0; flush = 1'b0;
    cfg_mode = DMA_DIRECT_MODE; cfg_min_addr = '0; cfg_max_addr = '0; cfg_len = '0;
    aw_stall = 1'b0; w_stall = 1'b0; t_gaps = 1'b0; err_burst = -1;
    repeat (4) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cur_addr", 64'(cur_addr), 64'd0);
    check("rst_beats", 64'(beats_done), 64'd0);
    check("rst_valids", {61'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: direct, two full 16-beat bursts
    aw_base = aw_addr_log.size(); wt_base = w_total;
    do_start(DMA_DIRECT_MODE, 32'h1000, 32'h0, 32'd256);
    lat = 1;
    while (!m_axi_awvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t1_aw_latency", 64'(lat), 64'd2);
    wait_done("t1");
    check("t1_aw_count", 64'(aw_addr_log.size() - aw_base), 64'd2);
    check("t1_aw0_addr", aw_addr_at(aw_base), 64'h1000);
    check("t1_aw0_len", aw_len_at(aw_base), 64'd15);
    check("t1_aw1_addr", aw_addr_at(aw_base + 1), 64'h1080);
    check("t1_aw1_len", aw_len_at(aw_base + 1), 64'd15);
    check("t1_beats_done", 64'(beats_done), 64'd32);
    check("t1_cur_addr", 64'(cur_addr), 64'h1100);
    check("t1_w_beats", 64'(w_total - wt_base), 64'd32);
    check("t1_err", 64'(err), 64'd0);
    check_pulse_end("t1");

    // 2: direct, split at the 4KB boundary
    aw_base = aw_addr_log.size();
    do_start(DMA_DIRECT_MODE, 32'h1FC0, 32'h0, 32'd128);
    wait_done("t2");
    check("t2_aw_count", 64'(aw_addr_log.size() - aw_base), 64'd2);
    check("t2_aw0_addr", aw_addr_at(aw_base), 64'h1FC0);
    check("t2_aw0_len", aw_len_at(aw_base), 64'd7);
    check("t2_aw1_addr", aw_addr_at(aw_base + 1), 64'h2000);
    check("t2_aw1_len", aw_len_at(aw_base + 1), 64'd7);
    check("t2_cur_addr", 64'(cur_addr), 64'h2040);
    check("t2_beats_done", 64'(beats_done), 64'd16);

    // 3: circular wrap with slave stalls
    aw_stall = 1'b1; w_stall = 1'b1;
    aw_base = aw_addr_log.size();
    do_start(DMA_CIRCULAR_MODE, 32'h0, 32'h40, 32'd128);
    wait_done("t3");
    check("t3_aw_count", 64'(aw_addr_log.size() - aw_base), 64'd2);
    check("t3_aw0_addr", aw_addr_at(aw_base), 64'h0);
    check("t3_aw0_len", aw_len_at(aw_base), 64'd7);
    check("t3_aw1_addr", aw_addr_at(aw_base + 1), 64'h0);
    check("t3_aw1_len", aw_len_at(aw_base + 1), 64'd7);
    check("t3_cur_addr", 64'(cur_addr), 64'h0);
    check("t3_beats_done", 64'(beats_done), 64'd16);
    aw_stall = 1'b0; w_stall = 1'b0;

    // 4a: zero length
    aw_base = aw_addr_log.size();
    do_start(DMA_DIRECT_MODE, 32'h500, 32'h0, 32'd0);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t4a_done_latency", 64'(lat), 64'd2);
    check("t4a_err", 64'(err), 64'd0);
    check_pulse_end("t4a");
    // 4b: less than one beat rounds down to zero
    do_start(DMA_DIRECT_MODE, 32'h600, 32'h0, 32'd7);
    wait_done("t4b");
    check("t4b_beats_done", 64'(beats_done), 64'd0);
    // 4c: circular with an empty window
    do_start(DMA_CIRCULAR_MODE, 32'h100, 32'h100, 32'd64);
    wait_done("t4c");
    check("t4c_err", 64'(err), 64'd1);
    check("t4_no_aw", 64'(aw_addr_log.size() - aw_base), 64'd0);
    check_pulse_end("t4c");

    // 5: SLVERR on the first of two bursts, then a clean job clears err
    aw_base = aw_addr_log.size();
    err_burst = b_total;
    do_start(DMA_DIRECT_MODE, 32'h4000, 32'h0, 32'd256);
    wait_done("t5");
    check("t5_err", 64'(err), 64'd1);
    check("t5_aw_count", 64'(aw_addr_log.size() - aw_base), 64'd1);
    check("t5_beats_done", 64'(beats_done), 64'd16);
    check_pulse_end("t5");
    check("t5_err_sticky", 64'(err), 64'd1);
    err_burst = -1;
    aw_base = aw_addr_log.size();
    do_start(DMA_DIRECT_MODE, 32'h5000, 32'h0, 32'd64);
    check("t5_err_cleared", 64'(err), 64'd0);
    wait_done("t5b");
    check("t5b_aw_addr", aw_addr_at(aw_base), 64'h5000);
    check("t5b_aw_len", aw_len_at(aw_base), 64'd7);
    check("t5b_err", 64'(err), 64'd0);

    // 6: flush in the first burst of a 3-burst job, with stalls, gaps and a start while busy
    aw_stall = 1'b1; w_stall = 1'b1; t_gaps = 1'b1;
    aw_base = aw_addr_log.size(); wt_base = w_total;
    do_start(DMA_DIRECT_MODE, 32'h3000, 32'h0, 32'd384);
    lat = 0;
    while (dbg_state != 3'(WR_W) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("t6_reached_w", 64'(dbg_state), 64'(WR_W));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cfg_min_addr = 32'h8000; cfg_len = 32'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6");
    check("t6_aw_count", 64'(aw_addr_log.size() - aw_base), 64'd1);
    check("t6_aw_addr", aw_addr_at(aw_base), 64'h3000);
    check("t6_aw_len", aw_len_at(aw_base), 64'd15);
    check("t6_w_beats", 64'(w_total - wt_base), 64'd16);
    check("t6_beats_done", 64'(beats_done), 64'd16);
    check("t6_cur_addr", 64'(cur_addr), 64'h3080);
    check("t6_err", 64'(err), 64'd0);
    repeat (6) @(negedge clk);
    check("t6_no_late_aw", 64'(aw_addr_log.size() - aw_base), 64'd1);
    check("t6_idle", 64'(busy), 64'd0);

    check("bus_w_protocol_errs", 64'(w_bad), 64'd0);
    check("bus_aw_attr_errs", 64'(aw_bad), 64'd0);
    check("bus_b_outstanding", 64'(b_pend), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
